// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch-stage bus: memory-stage redirect, instruction port and IF/ID outputs
interface if_fetch_stage_if;
  logic        i_stall;
  logic        i_PCSrc;
  logic [31:0] i_branchTarget;
  logic [31:0] o_if_instrAddr;
  logic [31:0] i_if_instr;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_pcPlus4;
  logic [31:0] o_id_instr;
  logic        o_id_valid;
  logic        o_fault;
  logic [31:0] o_faultAddr;
  logic [15:0] o_redirectCount;

  modport master (
    input  i_stall, i_PCSrc, i_branchTarget, i_if_instr,
    output o_if_instrAddr, o_id_pc, o_id_pcPlus4, o_id_instr, o_id_valid,
           o_fault, o_faultAddr, o_redirectCount
  );

  modport slave (
    output i_stall, i_PCSrc, i_branchTarget, i_if_instr,
    input  o_if_instrAddr, o_id_pc, o_id_pcPlus4, o_id_instr, o_id_valid,
           o_fault, o_faultAddr, o_redirectCount
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch: PC register, IF/ID register, redirect/stall/fault handling
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic              i_clk,
  input logic              i_reset,
  if_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] redirect_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= BOOT;
      pc_q           <= RESET_PC;
      id_pc          <= 32'd0;
      id_pc_plus4    <= 32'd0;
      id_instr       <= NOP_INSTR;
      id_valid       <= 1'b0;
      fault          <= 1'b0;
      fault_addr     <= 32'd0;
      redirect_count <= 16'd0;
    end else begin
      case (state)
        // BOOT only gives the instruction memory one cycle to read RESET_PC
        BOOT: state <= RUN;
        RUN: begin
          if (bus.i_PCSrc && (bus.i_branchTarget[1:0] != 2'b00)) begin
            state       <= HALT;
            fault       <= 1'b1;
            fault_addr  <= bus.i_branchTarget;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd0;
            id_instr    <= NOP_INSTR;
            id_valid    <= 1'b0;
          end else if (bus.i_PCSrc) begin
            pc_q        <= bus.i_branchTarget;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd0;
            id_instr    <= NOP_INSTR;
            id_valid    <= 1'b0;
            if (redirect_count != 16'hFFFF) begin
              redirect_count <= redirect_count + 16'd1;
            end
          end else if (!bus.i_stall) begin
            id_pc       <= pc_q;
            id_pc_plus4 <= pc_q + 32'd4;
            id_instr    <= bus.i_if_instr;
            id_valid    <= 1'b1;
            pc_q        <= pc_q + 32'd4;
          end
        end
        // HALT is left only through reset; IF/ID already holds the bubble
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  assign bus.o_if_instrAddr  = pc_q;
  assign bus.o_id_pc         = id_pc;
  assign bus.o_id_pcPlus4    = id_pc_plus4;
  assign bus.o_id_instr      = id_instr;
  assign bus.o_id_valid      = id_valid;
  assign bus.o_fault         = fault;
  assign bus.o_faultAddr     = fault_addr;
  assign bus.o_redirectCount = redirect_count;

endmodule
